// File: rtl/sar_pkg.sv
// Shared definitions for the SAR comparator responder.
// Holds the default code width, the responder state encoding and the
// noise-LFSR constants with its step function.
package sar_pkg;

  localparam int unsigned SAR_WIDTH = 8;
  localparam int unsigned LFSR_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SETTLE
  } sar_state_e;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 as a mask over bits [7:0].
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // One Fibonacci step: tap parity enters at the MSB, bit 0 falls out.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/sar_cmp_lfsr.sv
// Noise source for equality decisions.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (reloads seed)
//   step      : advance the LFSR by one state this cycle
//   noise     : current LFSR bit 0
module sar_cmp_lfsr
  import sar_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic noise
);

  logic [LFSR_W-1:0] state;

  // LFSR register, advanced once per issued decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

  assign noise = state[0];

endmodule

// File: rtl/sar_cmp_responder.sv
// Comparator / sample-and-hold model answering an 8-bit SAR controller.
// Captures one sample per conversion, answers each trial code with
// (held >= trial) after SETTLE_CYCLES, and releases on conv_done.
// Optional macro SAR_CMP_NOISE_EN: equality decisions take an LFSR bit.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   sample_valid/in     : new sample offer, accepted while sample_ready
//   sample_ready        : high only while idle
//   trial_valid/code    : one-cycle trial strobe and DAC code
//   cmp_out, cmp_valid  : decision (held) and its one-cycle update pulse
//   conv_done           : conversion complete, drop the held sample
//   held_value          : held sample, 0 while idle
//   overrun             : sticky, more than WIDTH trials in one conversion
module sar_cmp_responder
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = SAR_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  output logic             sample_ready,
  input  logic             trial_valid,
  input  logic [WIDTH-1:0] trial_code,
  output logic             cmp_out,
  output logic             cmp_valid,
  input  logic             conv_done,
  output logic [WIDTH-1:0] held_value,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SET_W = 4;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(WIDTH);

  sar_state_e       state, state_n;
  logic [WIDTH-1:0] held_n;
  logic [WIDTH-1:0] trial_q, trial_n;
  logic [WIDTH-1:0] cmp_trial;
  logic [CNT_W-1:0] trial_cnt, cnt_n;
  logic [SET_W-1:0] settle_cnt, settle_n;
  logic             cmp_out_n, cmp_valid_n, overrun_n, ready_n;
  logic             decide;

`ifdef SAR_CMP_NOISE_EN
  logic noise;

  sar_cmp_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (decide),
    .noise (noise)
  );
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      held_value   <= '0;
      trial_q      <= '0;
      trial_cnt    <= '0;
      settle_cnt   <= '0;
      cmp_out      <= 1'b0;
      cmp_valid    <= 1'b0;
      overrun      <= 1'b0;
      sample_ready <= 1'b1;
    end else begin
      state        <= state_n;
      held_value   <= held_n;
      trial_q      <= trial_n;
      trial_cnt    <= cnt_n;
      settle_cnt   <= settle_n;
      cmp_out      <= cmp_out_n;
      cmp_valid    <= cmp_valid_n;
      overrun      <= overrun_n;
      sample_ready <= ready_n;
    end
  end

  // Next-state and output logic. The decision is registered on the edge
  // where the settle count reaches 0, so a one-cycle settle answers on the
  // cycle right after the strobe and conv_done can still cancel it.
  always_comb begin
    state_n     = state;
    held_n      = held_value;
    trial_n     = trial_q;
    cnt_n       = trial_cnt;
    settle_n    = settle_cnt;
    cmp_out_n   = cmp_out;
    cmp_valid_n = 1'b0;
    overrun_n   = overrun;
    decide      = 1'b0;
    cmp_trial   = trial_q;

    unique case (state)
      IDLE: begin
        if (sample_valid) begin
          held_n  = sample_in;
          cnt_n   = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (conv_done) begin
          state_n = IDLE;
          held_n  = '0;
          cnt_n   = '0;
        end else if (trial_valid) begin
          trial_n  = trial_code;
          settle_n = SETTLE_LOAD;
          if (trial_cnt == CNT_MAX) begin
            overrun_n = 1'b1;
          end
          if (settle_n == '0) begin
            decide    = 1'b1;
            cmp_trial = trial_code;
          end else begin
            state_n = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (conv_done) begin
          state_n = IDLE;
          held_n  = '0;
          cnt_n   = '0;
        end else begin
          settle_n = settle_cnt - SET_W'(1);
          if (settle_n == '0) begin
            decide  = 1'b1;
            state_n = HOLD;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Issue the decision and count the trial (saturating).
    if (decide) begin
      cmp_valid_n = 1'b1;
`ifdef SAR_CMP_NOISE_EN
      cmp_out_n = (held_value == cmp_trial) ? noise : (held_value >= cmp_trial);
`else
      cmp_out_n = (held_value >= cmp_trial);
`endif
      if (trial_cnt != CNT_MAX) begin
        cnt_n = trial_cnt + CNT_W'(1);
      end
    end

    ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_sar_cmp_responder.sv
// Self-checking bench for sar_cmp_responder: one instance with a one-cycle
// settle and one with a four-cycle settle, expected decisions queued at
// stimulus time and popped when cmp_valid fires.
module tb_sar_cmp_responder;

  logic       clk, rst;
  logic       sv1, tv1, cd1, sr1, co1, cv1, ov1;
  logic [7:0] si1, tc1, hv1;
  logic       sv4, tv4, cd4, sr4, co4, cv4, ov4;
  logic [7:0] si4, tc4, hv4;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  sar_cmp_responder #(.WIDTH(8), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(sv1), .sample_in(si1), .sample_ready(sr1),
    .trial_valid(tv1), .trial_code(tc1), .cmp_out(co1), .cmp_valid(cv1),
    .conv_done(cd1), .held_value(hv1), .overrun(ov1)
  );

  sar_cmp_responder #(.WIDTH(8), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .sample_valid(sv4), .sample_in(si4), .sample_ready(sr4),
    .trial_valid(tv4), .trial_code(tc4), .cmp_out(co4), .cmp_valid(cv4),
    .conv_done(cd4), .held_value(hv4), .overrun(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sv1 = 0; tv1 = 0; cd1 = 0; si1 = 0; tc1 = 0;
    sv4 = 0; tv4 = 0; cd4 = 0; si4 = 0; tc4 = 0;
    step(); step();
    rst = 1'b0;
    // Put dut4 into SETTLE, then reset it there.
    sv4 = 1; si4 = 8'h77; step(); sv4 = 0;
    tv4 = 1; tc4 = 8'h10; step(); tv4 = 0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++; if (cv4 !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_valid got %b want 0", cv4); end
    n_checks++; if (co4 !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_out got %b want 0", co4); end
    n_checks++; if (hv4 !== 8'h00) begin n_fail++; $display("FAIL reset_held got %h want 00", hv4); end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", ov4); end
    n_checks++; if (sr4 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", sr4); end
    n_checks++; if ({sr1, cv1, co1, ov1, hv1} !== {4'b1000, 8'h00}) begin
      n_fail++; $display("FAIL reset_dut1 got %b%b%b%b %h want 1000 00", sr1, cv1, co1, ov1, hv1);
    end
    // Nothing latent must surface from the aborted settle.
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (cv4 !== 1'b0) begin n_fail++; $display("FAIL reset_no_late_pulse got %b want 0", cv4); end
    end
  endtask

  task automatic test_idle_ignore();
    tv1 = 1; tc1 = 8'h00; cd1 = 1; step(); tv1 = 0; cd1 = 0;
    step();
    n_checks++; if (cv1 !== 1'b0) begin n_fail++; $display("FAIL idle_trial got cmp_valid %b want 0", cv1); end
    n_checks++; if (sr1 !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b want 1", sr1); end
  endtask

  task automatic test_binary_search();
    logic [7:0] codes [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
    logic       want  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       e;
    sv1 = 1; si1 = 8'h5A; step(); sv1 = 0;
    n_checks++; if (hv1 !== 8'h5A) begin n_fail++; $display("FAIL bs_capture got %h want 5a", hv1); end
    n_checks++; if (sr1 !== 1'b0) begin n_fail++; $display("FAIL bs_ready got %b want 0", sr1); end
    for (int i = 0; i < 8; i++) begin
      tv1 = 1; tc1 = codes[i]; exp_q.push_back(want[i]);
      step(); tv1 = 0;
      n_checks++;
      if (cv1 !== 1'b1) begin
        n_fail++; $display("FAIL bs_latency trial %h got cmp_valid %b want 1", codes[i], cv1);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        n_checks++; if (co1 !== e) begin n_fail++; $display("FAIL bs_decision trial %h got %b want %b", codes[i], co1, e); end
      end
      step();
      n_checks++; if (cv1 !== 1'b0) begin n_fail++; $display("FAIL bs_pulse_width trial %h got %b want 0", codes[i], cv1); end
    end
    cd1 = 1; step(); cd1 = 0;
    n_checks++; if (sr1 !== 1'b1 || hv1 !== 8'h00) begin
      n_fail++; $display("FAIL bs_release got ready %b held %h want 1 00", sr1, hv1);
    end
    n_checks++; if (co1 !== 1'b0) begin n_fail++; $display("FAIL bs_cmp_hold got %b want 0", co1); end
  endtask

  task automatic test_latency();
    int   pulses = 0;
    int   first  = 0;
    logic e;
    sv4 = 1; si4 = 8'hFF; step(); sv4 = 0;
    for (int k = 1; k <= 12; k++) begin
      tv4 = (k == 1 || k == 3); tc4 = 8'h00;
      if (k == 1) exp_q.push_back(1'b1);
      step();
      if (cv4) begin
        pulses++;
        if (first == 0) first = k;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL lat_extra_pulse at %0d got pulse want none", k);
        end else begin
          e = exp_q.pop_front();
          if (co4 !== e) begin n_fail++; $display("FAIL lat_decision got %b want %b", co4, e); end
        end
      end
    end
    tv4 = 0;
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL lat_cycles got %0d want 4", first); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL lat_pulse_count got %0d want 1", pulses); end
    exp_q.delete();
    // conv_done on the settle-completion cycle cancels the decision.
    sv4 = 0; tc4 = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      tv4 = (k == 1);
      cd4 = (k == 4);
      step();
      n_checks++; if (cv4 !== 1'b0) begin n_fail++; $display("FAIL lat_cancel at %0d got cmp_valid %b want 0", k, cv4); end
    end
    tv4 = 0; cd4 = 0;
    n_checks++; if (sr4 !== 1'b1 || hv4 !== 8'h00) begin
      n_fail++; $display("FAIL lat_cancel_idle got ready %b held %h want 1 00", sr4, hv4);
    end
    n_checks++; if (co4 !== 1'b1) begin n_fail++; $display("FAIL lat_cmp_hold got %b want 1", co4); end
  endtask

  task automatic test_overrun();
    logic [7:0] code;
    logic       e;
    sv1 = 1; si1 = 8'h10; step(); sv1 = 0;
    for (int i = 0; i < 9; i++) begin
      code = 8'(i * 8'h05);
      tv1 = 1; tc1 = code; exp_q.push_back(8'h10 >= code);
      step(); tv1 = 0;
      n_checks++;
      if (cv1 !== 1'b1) begin
        n_fail++; $display("FAIL ovr_valid trial %0d got %b want 1", i, cv1); exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (co1 !== e) begin n_fail++; $display("FAIL ovr_decision trial %0d got %b want %b", i, co1, e); end
      end
      n_checks++; if (ov1 !== (i == 8)) begin n_fail++; $display("FAIL ovr_flag trial %0d got %b want %b", i, ov1, (i == 8)); end
      step();
    end
    cd1 = 1; step(); cd1 = 0; step();
    n_checks++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", ov1); end
    n_checks++; if (sr1 !== 1'b1) begin n_fail++; $display("FAIL ovr_release got ready %b want 1", sr1); end
    rst = 1; step(); rst = 0;
    n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", ov1); end
  endtask

  task automatic test_release();
    logic e;
    sv1 = 1; si1 = 8'h33; step(); sv1 = 0;
    tv1 = 1; tc1 = 8'h00; cd1 = 1; step(); tv1 = 0; cd1 = 0;
    n_checks++; if (cv1 !== 1'b0) begin n_fail++; $display("FAIL rel_no_pulse got %b want 0", cv1); end
    n_checks++; if (sr1 !== 1'b1 || hv1 !== 8'h00) begin
      n_fail++; $display("FAIL rel_idle got ready %b held %h want 1 00", sr1, hv1);
    end
    step();
    n_checks++; if (cv1 !== 1'b0) begin n_fail++; $display("FAIL rel_no_late_pulse got %b want 0", cv1); end
    sv1 = 1; si1 = 8'h01; step(); sv1 = 0;
    n_checks++; if (hv1 !== 8'h01) begin n_fail++; $display("FAIL rel_recapture got %h want 01", hv1); end
    // Equality keeps the bit; one above clears it.
    for (int i = 1; i <= 2; i++) begin
      tv1 = 1; tc1 = 8'(i); exp_q.push_back(8'h01 >= 8'(i));
      step(); tv1 = 0;
      n_checks++;
      if (cv1 !== 1'b1) begin
        n_fail++; $display("FAIL rel_valid trial %0d got %b want 1", i, cv1); exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (co1 !== e) begin n_fail++; $display("FAIL rel_decision trial %0d got %b want %b", i, co1, e); end
      end
      step();
    end
    cd1 = 1; step(); cd1 = 0;
  endtask

  task automatic test_noise();
    logic [7:0] l = 8'hA5;
    logic       e;
    rst = 1; step(); rst = 0;
    sv1 = 1; si1 = 8'h80; step(); sv1 = 0;
    for (int i = 0; i < 16; i++) begin
`ifdef SAR_CMP_NOISE_EN
      exp_q.push_back(l[0]);
      l = {^(l & 8'hB8), l[7:1]};
`else
      exp_q.push_back(1'b1);
`endif
      tv1 = 1; tc1 = 8'h80;
      step(); tv1 = 0;
      n_checks++;
      if (cv1 !== 1'b1) begin
        n_fail++; $display("FAIL noise_valid trial %0d got %b want 1", i, cv1); exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (co1 !== e) begin n_fail++; $display("FAIL noise_bit trial %0d got %b want %b", i, co1, e); end
      end
      step();
    end
    cd1 = 1; step(); cd1 = 0;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_binary_search();
    test_latency();
    test_overrun();
    test_release();
    test_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
